// File: rtl/eth_tx_sched_pkg.sv
// Shared types and defaults for the transmit scheduler and its round-robin picker.
package eth_tx_sched_pkg;

   localparam int BYTE_LEN_DEF    = 8;
   localparam int STALL_LIMIT_DEF = 1024;
   localparam int FRAME_CNT_W     = 16;

   // state      | meaning
   // ST_IDLE    | no owner, waiting for any req
   // ST_START   | owner chosen, tx_start pulse to eth_tx
   // ST_ACTIVE  | owner's byte stream muxed to eth_tx, watchdog running
   // ST_WAIT_DONE | payload finished or aborted, waiting for end of gap
   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_START     = 2'd1,
      ST_ACTIVE    = 2'd2,
      ST_WAIT_DONE = 2'd3
   } state_t;

   // Index width for up to four sources; one bit is enough for two.
   function automatic int idx_width(input int n);
      return (n > 2) ? 2 : 1;
   endfunction

endpackage

// File: rtl/eth_tx_sched_rr_pick.sv
// Combinational round-robin selector: first requester strictly after 'last',
// wrapping modulo N. Reusable by any arbiter that keeps its own 'last'.
module eth_tx_sched_rr_pick
   import eth_tx_sched_pkg::*;
#(
   parameter int N  = 2,
   parameter int IW = idx_width(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] last,
   output logic [N-1:0]  onehot,
   output logic [IW-1:0] idx,
   output logic          valid
);

   logic [IW:0] cand;

   // Scan candidates from farthest to nearest so the nearest requester wins.
   always_comb begin
      onehot = '0;
      idx    = '0;
      valid  = 1'b0;
      cand   = '0;
      for (int k = N; k >= 1; k--) begin
         cand = {1'b0, last} + (IW+1)'(k);
         if (cand >= (IW+1)'(N)) begin
            cand = cand - (IW+1)'(N);
         end
         if (req[cand[IW-1:0]]) begin
            onehot                = '0;
            onehot[cand[IW-1:0]]  = 1'b1;
            idx                   = cand[IW-1:0];
            valid                 = 1'b1;
         end
      end
   end

endmodule

// File: rtl/eth_tx_sched.sv
// Round-robin transmit scheduler: shares one eth_tx frame generator among
// NUM_SRC payload sources, one frame per grant, with a stall watchdog.
module eth_tx_sched
   import eth_tx_sched_pkg::*;
#(
   parameter int NUM_SRC     = 2,
   parameter int BYTE_LEN    = BYTE_LEN_DEF,
   parameter int STALL_LIMIT = STALL_LIMIT_DEF
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_SRC-1:0]            req,
   input  logic [NUM_SRC-1:0]            src_inclk,
   input  logic [NUM_SRC*BYTE_LEN-1:0]   src_in,
   input  logic [NUM_SRC-1:0]            src_in_done,
   output logic [NUM_SRC-1:0]            src_readclk,
   output logic [NUM_SRC-1:0]            grant,
   output logic                          tx_start,
   output logic                          tx_inclk,
   output logic [BYTE_LEN-1:0]           tx_in,
   output logic                          tx_in_done,
   input  logic                          tx_upstream_readclk,
   input  logic                          tx_done,
   output logic                          busy,
   output logic                          abort,
   output logic [FRAME_CNT_W-1:0]        frame_cnt
);

   localparam int IW   = idx_width(NUM_SRC);
   localparam int WD_W = $clog2(STALL_LIMIT + 1);
   localparam logic [WD_W-1:0] WD_EXPIRE = WD_W'(STALL_LIMIT - 1);

   state_t               state;
   logic [IW-1:0]        last;
   logic [WD_W-1:0]      wd;

   logic [NUM_SRC-1:0]   pick_onehot;
   logic [IW-1:0]        pick_idx;
   logic                 pick_valid;

   logic [BYTE_LEN-1:0]  src_bytes [NUM_SRC];
   logic [BYTE_LEN-1:0]  g_byte;
   logic                 g_inclk;
   logic                 g_done;
   logic                 in_active;
   logic                 activity;
   logic                 expire;

   eth_tx_sched_rr_pick #(
      .N  (NUM_SRC),
      .IW (IW)
   ) u_pick (
      .req    (req),
      .last   (last),
      .onehot (pick_onehot),
      .idx    (pick_idx),
      .valid  (pick_valid)
   );

   for (genvar i = 0; i < NUM_SRC; i++) begin : g_slice
      assign src_bytes[i] = src_in[i*BYTE_LEN +: BYTE_LEN];
   end

   // 'last' doubles as the owner index while a frame is in flight.
   assign g_inclk   = src_inclk[last];
   assign g_done    = src_in_done[last];
   assign g_byte    = src_bytes[last];
   assign in_active = (state == ST_ACTIVE);
   assign activity  = g_inclk | tx_upstream_readclk;
   // A real done on the expiry cycle wins; any activity also rescues the frame.
   assign expire    = in_active && !g_done && !activity && (wd == WD_EXPIRE);

   assign busy       = (state != ST_IDLE);
   assign abort      = expire;
   assign tx_inclk   = in_active & g_inclk;
   assign tx_in      = in_active ? g_byte : '0;
   assign tx_in_done = in_active & (g_done | expire);

   // Route the eth_tx read strobe back to the owner only.
   always_comb begin
      src_readclk = '0;
      if (in_active) begin
         src_readclk[last] = tx_upstream_readclk;
      end
   end

   // Frame sequencing, grant/start registers, watchdog and frame counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         grant     <= '0;
         last      <= IW'(NUM_SRC - 1);
         wd        <= '0;
         tx_start  <= 1'b0;
         frame_cnt <= '0;
      end else begin
         tx_start <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (pick_valid) begin
                  grant    <= pick_onehot;
                  last     <= pick_idx;
                  tx_start <= 1'b1;
                  state    <= ST_START;
               end
            end
            ST_START: begin
               wd    <= '0;
               state <= ST_ACTIVE;
            end
            ST_ACTIVE: begin
               if (g_done || expire) begin
                  wd    <= '0;
                  state <= ST_WAIT_DONE;
               end else if (activity) begin
                  wd <= '0;
               end else begin
                  wd <= wd + 1'b1;
               end
            end
            ST_WAIT_DONE: begin
               if (tx_done) begin
                  frame_cnt <= frame_cnt + 1'b1;
                  grant     <= '0;
                  state     <= ST_IDLE;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_eth_tx_sched.sv
// Scoreboard bench for eth_tx_sched: stimulus pushes expected observations,
// a negedge monitor pops and compares whatever the DUT presents.
module tb_eth_tx_sched;

   localparam int NS = 2;
   localparam int BL = 8;
   localparam int SL = 16;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic [NS-1:0]  req = '0;
   logic [NS-1:0]  src_inclk = '0;
   logic [NS*BL-1:0] src_in = '0;
   logic [NS-1:0]  src_in_done = '0;
   logic           tx_upstream_readclk = 1'b0;
   logic           tx_done = 1'b0;

   logic [NS-1:0]  src_readclk;
   logic [NS-1:0]  grant;
   logic           tx_start;
   logic           tx_inclk;
   logic [BL-1:0]  tx_in;
   logic           tx_in_done;
   logic           busy;
   logic           abort;
   logic [15:0]    frame_cnt;

   int n_checks = 0;
   int n_errors = 0;
   int exp_fc   = 0;
   bit outstanding = 1'b0;
   logic [15:0] exp_q [$];

   eth_tx_sched #(
      .NUM_SRC     (NS),
      .BYTE_LEN    (BL),
      .STALL_LIMIT (SL)
   ) dut (
      .clk                 (clk),
      .rst                 (rst),
      .req                 (req),
      .src_inclk           (src_inclk),
      .src_in              (src_in),
      .src_in_done         (src_in_done),
      .src_readclk         (src_readclk),
      .grant               (grant),
      .tx_start            (tx_start),
      .tx_inclk            (tx_inclk),
      .tx_in               (tx_in),
      .tx_in_done          (tx_in_done),
      .tx_upstream_readclk (tx_upstream_readclk),
      .tx_done             (tx_done),
      .busy                (busy),
      .abort               (abort),
      .frame_cnt           (frame_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic compare_obs(input logic [15:0] obs);
      logic [15:0] e;
      n_checks++;
      if (exp_q.size() == 0) begin
         n_errors++;
         $display("FAIL unexpected_output: got %04h expected nothing at %0t", obs, $time);
      end else begin
         e = exp_q.pop_front();
         if (obs !== e) begin
            n_errors++;
            $display("FAIL output_stream: got %04h expected %04h at %0t", obs, e, $time);
         end
      end
   endtask

   // Observation codes: 1=start(grant), 2=byte(done,data), 3=done-without-byte(abort,done).
   initial begin
      forever begin
         @(negedge clk);
         if (rst) begin
            outstanding = 1'b0;
         end else begin
            if (tx_start) begin
               check("start_overlap", 32'(outstanding), 32'd0);
               outstanding = 1'b1;
               compare_obs({4'h1, 2'b00, grant, 8'h00});
            end
            if (tx_inclk) begin
               compare_obs({4'h2, 3'b000, tx_in_done, tx_in});
            end else if (tx_in_done || abort) begin
               compare_obs({4'h3, 2'b00, abort, tx_in_done, 8'h00});
            end
            if (tx_done) outstanding = 1'b0;
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_src();
      src_inclk = '0;
      src_in = '0;
      src_in_done = '0;
      tx_upstream_readclk = 1'b0;
   endtask

   task automatic wait_start(input logic [1:0] exp_g, output int lat);
      exp_q.push_back({4'h1, 2'b00, exp_g, 8'h00});
      lat = 0;
      while (!tx_start && lat < 8) begin
         step();
         lat++;
      end
      check("tx_start_seen", 32'(tx_start), 32'd1);
      check("grant", 32'(grant), 32'(exp_g));
   endtask

   task automatic end_frame();
      check("wait_busy", 32'(busy), 32'd1);
      check("wait_mux_quiet", {30'd0, tx_inclk, tx_in_done}, 32'd0);
      step();
      tx_done = 1'b1;
      step();
      tx_done = 1'b0;
      exp_fc++;
      check("frame_cnt", 32'(frame_cnt), 32'(exp_fc));
      check("grant_clear", 32'(grant), 32'd0);
      check("busy_clear", 32'(busy), 32'd0);
   endtask

   task automatic run_frame(input int src, input logic [1:0] exp_g, input logic [1:0] clr,
                            input logic [7:0] base, input int n, input int pre_idle,
                            input bit noise, output int lat);
      int oth;
      logic rc;
      logic last_b;
      oth = 1 - src;
      wait_start(exp_g, lat);
      req = req & ~clr;
      step();
      repeat (pre_idle) step();
      for (int i = 0; i < n; i++) begin
         rc = noise ? (i % 2 == 0) : 1'b1;
         last_b = (i == n - 1);
         clear_src();
         src_inclk[src] = 1'b1;
         src_in[src*BL +: BL] = base + 8'(i);
         src_in_done[src] = last_b;
         if (noise) begin
            src_inclk[oth] = i[0];
            src_in[oth*BL +: BL] = 8'hFF;
            src_in_done[oth] = 1'b1;
         end
         tx_upstream_readclk = rc;
         exp_q.push_back({4'h2, 3'b000, last_b, base + 8'(i)});
         #1;
         check("src_readclk", 32'(src_readclk), rc ? (32'd1 << src) : 32'd0);
         step();
      end
      clear_src();
      end_frame();
   endtask

   initial begin
      int lat;
      repeat (2) step();
      rst = 1'b0;
      check("rst_grant", 32'(grant), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_frame_cnt", 32'(frame_cnt), 32'd0);
      check("rst_outs", {27'd0, tx_start, tx_inclk, tx_in_done, abort, |src_readclk}, 32'd0);

      // Single source 0, bytes A0..A3, one-cycle grant latency.
      req = 2'b01;
      run_frame(0, 2'b01, 2'b01, 8'hA0, 4, 0, 1'b0, lat);
      check("start_latency", 32'(lat), 32'd1);

      // Spurious tx_done in IDLE is not counted.
      tx_done = 1'b1;
      step();
      tx_done = 1'b0;
      step();
      check("spurious_done_cnt", 32'(frame_cnt), 32'(exp_fc));
      check("spurious_done_busy", 32'(busy), 32'd0);

      // Source 1 chatters while source 0 owns the link.
      req = 2'b01;
      run_frame(0, 2'b01, 2'b01, 8'hC0, 4, 0, 1'b1, lat);

      // Both requesting from reset: 01, 10, 01.
      rst = 1'b1;
      step();
      rst = 1'b0;
      exp_fc = 0;
      check("rst2_frame_cnt", 32'(frame_cnt), 32'd0);
      req = 2'b11;
      run_frame(0, 2'b01, 2'b00, 8'h10, 3, 0, 1'b0, lat);
      check("rr_latency", 32'(lat), 32'd1);
      run_frame(1, 2'b10, 2'b00, 8'h20, 2, 0, 1'b0, lat);
      run_frame(0, 2'b01, 2'b11, 8'h30, 1, 0, 1'b0, lat);

      // Stall: abort on the 16th silent ACTIVE cycle.
      req = 2'b01;
      wait_start(2'b01, lat);
      req = 2'b00;
      exp_q.push_back({4'h3, 2'b00, 1'b1, 1'b1, 8'h00});
      step();
      for (int i = 0; i < SL; i++) begin
         check("stall_abort", 32'(abort), (i == SL - 1) ? 32'd1 : 32'd0);
         if (i == SL - 1) begin
            check("stall_done_forced", {30'd0, tx_in_done, tx_inclk}, 32'd2);
         end
         step();
      end
      end_frame();

      // Done on the would-be expiry cycle: normal completion, no abort.
      req = 2'b01;
      run_frame(0, 2'b01, 2'b01, 8'hE0, 1, SL - 1, 1'b0, lat);

      // Reset in the middle of source 1's payload.
      req = 2'b10;
      wait_start(2'b10, lat);
      req = 2'b00;
      step();
      for (int i = 0; i < 2; i++) begin
         clear_src();
         src_inclk = 2'b10;
         src_in = {8'h70 + 8'(i), 8'h00};
         tx_upstream_readclk = 1'b1;
         exp_q.push_back({4'h2, 3'b000, 1'b0, 8'h70 + 8'(i)});
         #1;
         check("mid_readclk", 32'(src_readclk), 32'd2);
         step();
      end
      clear_src();
      rst = 1'b1;
      step();
      rst = 1'b0;
      exp_fc = 0;
      check("midrst_grant", 32'(grant), 32'd0);
      check("midrst_busy", 32'(busy), 32'd0);
      check("midrst_frame_cnt", 32'(frame_cnt), 32'd0);
      req = 2'b11;
      run_frame(0, 2'b01, 2'b11, 8'h50, 2, 0, 1'b0, lat);

      repeat (3) step();
      check("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
